nx_fifo_rd_stage: RTL and testbench



---
 rtl/nx_fifo_rd_stage_pkg.sv | 12 +
 rtl/nx_fifo_rd_stage.sv | 104 ++++++++++
 tb/tb_nx_fifo_rd_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/nx_fifo_rd_stage_pkg.sv
// Shared types for the FIFO read stage: occupancy encoding and buffer depth.
package nx_fifo_rd_stage_pkg;

    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/nx_fifo_rd_stage.sv
// Show-ahead FIFO pop interface to registered valid/ready stream via a 2-entry buffer.
// Latency: FIFO head word appears on out_data one cycle after it is popped.
// Backpressure: fifo_ren depends only on registered occupancy; out_valid/out_data hold until accepted.
module nx_fifo_rd_stage #(
    parameter int WIDTH      = 64,
    parameter int CNT_W      = 32,
    parameter bit DATA_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_ren,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] word_cnt
);
    import nx_fifo_rd_stage_pkg::*;

    occ_e             occ_q;
    occ_e             occ_d;
    logic             push;
    logic             pop;
    logic             wr_idx_q;
    logic             rd_idx_q;
    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [CNT_W-1:0] word_cnt_q;

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    // Occupancy next state: occ + push - pop, flush empties the buffer
    always_comb begin
        occ_d = occ_q;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (push) occ_d = OCC_ONE;
            end
            OCC_ONE: begin
                if (push && !pop)      occ_d = OCC_TWO;
                else if (pop && !push) occ_d = OCC_EMPTY;
            end
            OCC_TWO: begin
                if (pop) occ_d = OCC_ONE;
            end
            default: occ_d = OCC_EMPTY;
        endcase
        if (flush) occ_d = OCC_EMPTY;
    end

    // Outputs decoded from registered occupancy only; out_ready never reaches fifo_ren
    always_comb begin
        out_valid = (occ_q != OCC_EMPTY);
        fifo_ren  = !rst && !flush && !fifo_empty && (occ_q != OCC_TWO);
    end

    assign push = fifo_ren;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
        end else begin
            if (push) wr_idx_q <= !wr_idx_q;
            if (pop)  rd_idx_q <= !rd_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_idx_q] <= fifo_rdata;
    end

    // A transfer on the flush cycle still counts as delivered
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
        end else if (pop) begin
            word_cnt_q <= word_cnt_q + CNT_W'(1);
        end
    end

    assign out_data  = (DATA_RESET && !out_valid) ? '0 : mem_q[rd_idx_q];
    assign occupancy = occ_q;
    assign word_cnt  = word_cnt_q;

    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(pop && (occ_q == OCC_EMPTY)))
        else $error("nx_fifo_rd_stage: pop with occupancy 0");

    a_no_ren_when_fifo_empty: assert property (@(posedge clk)
        !(fifo_ren && fifo_empty))
        else $error("nx_fifo_rd_stage: fifo_ren asserted while fifo_empty");

endmodule

// File: tb/tb_nx_fifo_rd_stage.sv
// Scoreboard bench for nx_fifo_rd_stage: queue-based upstream FIFO and stage model, separate output monitor.
module tb_nx_fifo_rd_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_ren;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] word_cnt;

    nx_fifo_rd_stage #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W),
        .DATA_RESET (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_ren   (fifo_ren),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .occupancy  (occupancy),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] up_q [$];   // upstream FIFO contents, head at index 0
    logic [WIDTH-1:0] exp_q [$];  // words held in the stage, in delivery order
    logic [CNT_W-1:0] wc_model;
    bit               model_valid;
    int               n_checks;
    int               n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational/state outputs at +1,
    // apply flush/reset effects to the model at +3 after the monitor has run.
    task automatic cycle(input bit r, input bit f, input bit rdy);
        bit exp_ren;
        @(negedge clk);
        rst        = r;
        flush      = f;
        out_ready  = rdy;
        fifo_empty = (up_q.size() == 0);
        fifo_rdata = fifo_empty ? WIDTH'($urandom) : up_q[0];
        #1;
        exp_ren = !r && !f && !fifo_empty && (exp_q.size() < 2);
        check("fifo_ren", fifo_ren, exp_ren);
        if (model_valid) begin
            check("occupancy", occupancy, exp_q.size());
            check("out_valid", out_valid, exp_q.size() != 0);
            check("word_cnt", word_cnt, wc_model);
            if (exp_q.size() == 0) check("out_data_gated", out_data, 0);
        end
        if (fifo_ren === 1'b1 && up_q.size() != 0) exp_q.push_back(up_q.pop_front());
        #2;
        if (r) begin
            exp_q.delete();
            wc_model    = '0;
            model_valid = 1'b1;
        end else if (f) begin
            exp_q.delete();
        end
    endtask

    task automatic feed(input int first, input int n);
        for (int i = 0; i < n; i++) up_q.push_back(WIDTH'(first + i));
    endtask

    // Monitor: every accepted output word is compared against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (model_valid && !rst && out_valid === 1'b1 && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
                wc_model = wc_model + 1'b1;
            end
        end
    end

    initial begin
        rst         = 1'b1;
        flush       = 1'b0;
        out_ready   = 1'b0;
        fifo_empty  = 1'b1;
        fifo_rdata  = '0;
        wc_model    = '0;
        model_valid = 1'b0;
        n_checks    = 0;
        n_err       = 0;

        repeat (3) cycle(1, 0, 0);

        // Single word latency
        up_q.push_back(WIDTH'(32'hA5));
        repeat (4) cycle(0, 0, 1);

        // Full-rate streaming of 8 words
        feed(1, 8);
        repeat (12) cycle(0, 0, 1);

        // Backpressure to full, then drain across index wrap
        feed(1, 3);
        repeat (4) cycle(0, 0, 0);
        repeat (6) cycle(0, 0, 1);

        // Flush while full with a transfer on the flush cycle
        feed(16, 4);
        repeat (3) cycle(0, 0, 0);
        cycle(0, 1, 1);
        up_q.delete();
        repeat (3) cycle(0, 0, 1);

        // Reset while full with FIFO non-empty
        feed(32, 4);
        repeat (3) cycle(0, 0, 0);
        cycle(1, 0, 1);
        repeat (8) cycle(0, 0, 1);

        // Counter wrap: 20 accepted words at full rate
        feed(64, 20);
        repeat (24) cycle(0, 0, 1);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            bit r;
            bit f;
            bit rdy;
            if ($urandom_range(0, 2) == 0 && up_q.size() < 6) begin
                int k;
                k = $urandom_range(1, 3);
                for (int j = 0; j < k; j++) up_q.push_back(WIDTH'($urandom));
            end
            r   = ($urandom_range(0, 99) == 0);
            f   = ($urandom_range(0, 39) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            if (f && $urandom_range(0, 1) == 0) up_q.delete();
            cycle(r, f, rdy);
        end

        repeat (20) cycle(0, 0, 1);
        check("drained", exp_q.size(), 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
